// File: rtl/ifetch_unit_if.sv
// ----------------------------------------------------------------------------
// ifetch_unit_if
//
// Purpose : groups the two handshake bundles of the instruction fetch stage:
//           the instruction-memory request/response bus and the valid/ready
//           instruction stream towards decode.
//
// Parameters:
//   PC_W         PC / instruction address width
//
// Signals:
//   imem_req     fetch request valid                  (fetch -> memory)
//   imem_addr    fetch address                        (fetch -> memory)
//   imem_gnt     memory accepts the request           (memory -> fetch)
//   imem_rvalid  in-order response valid              (memory -> fetch)
//   imem_rdata   response instruction word            (memory -> fetch)
//   inst_valid   instruction head valid               (fetch -> decode)
//   inst_ready   decode consumes the head             (decode -> fetch)
//   inst         head instruction word                (fetch -> decode)
//   inst_pc      PC of the head instruction           (fetch -> decode)
//   opcode       inst[6:0] for the decode Controller  (fetch -> decode)
//
// Modports:
//   master  the fetch unit side
//   slave   the environment side (memory + decode)
// ----------------------------------------------------------------------------
interface ifetch_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [PC_W-1:0] inst_pc;
    logic [6:0]      opcode;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output opcode
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  opcode
    );
endinterface

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//
// Purpose : instruction fetch stage in front of the decode Controller. Holds
//           the PC, issues in-order word fetches over a req/gnt + rvalid bus,
//           buffers returned words in a small FIFO and hands them to decode
//           with a valid/ready handshake. A redirect loads a new PC, empties
//           the FIFO and arranges for all fetches still in flight to be
//           discarded when their responses come back.
//
// Parameters:
//   PC_W      PC / address width
//   RESET_PC  PC loaded on reset
//   DEPTH     FIFO depth, also the cap on outstanding-plus-buffered fetches
//             (power of 2, >= 2)
//
// Ports:
//   clk             clock, rising edge
//   reset           synchronous active-high reset
//   bus             ifetch_unit_if.master (imem bus + decode stream)
//   redirect_valid  load redirect_pc and flush
//   redirect_pc     redirect target
//   fetch_fault     sticky misaligned-redirect flag
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : a redirect with redirect_pc[1:0] != 0 sets a sticky
//               fetch_fault that blocks further fetch requests until reset.
//   undefined : the low two redirect bits are simply dropped and
//               fetch_fault is tied low.
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    ifetch_unit_if.master   bus,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  resp_pc;
    logic [31:0]      fifo_inst [DEPTH];
    logic [PC_W-1:0]  fifo_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_nxt;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W:0]   in_use;

    logic             fetch_block;
    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;
    logic             drop;
    logic             head_valid;
    logic [31:0]      head_inst;
    logic [PC_W-1:0]  redirect_aligned;

    // Masking rather than slicing keeps every redirect_pc bit in use.
    assign redirect_aligned = redirect_pc & ~PC_W'(3);

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q;

    // Sticky until reset: a misaligned target means the program is broken.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
    assign fetch_block = fault_q;
`else
    assign fetch_fault = 1'b0;
    assign fetch_block = 1'b0;
`endif

    // A request is only raised when a FIFO slot is guaranteed for its
    // response, counting both buffered words and fetches still in flight.
    assign in_use       = {1'b0, fifo_count} + {1'b0, outstanding};
    assign bus.imem_req = !reset && !redirect_valid && !fetch_block
                          && (in_use < (CNT_W + 1)'(DEPTH));
    assign bus.imem_addr = pc;

    assign issue = bus.imem_req && bus.imem_gnt;
    // Responses with nothing outstanding belong to requests issued before
    // reset and are ignored.
    assign resp  = bus.imem_rvalid && (outstanding != '0);
    assign drop  = resp && (drop_cnt != '0);
    assign push  = resp && !redirect_valid && (drop_cnt == '0);
    assign pop   = head_valid && bus.inst_ready && !redirect_valid;

    always_comb begin
        outstanding_nxt = outstanding;
        if (issue && !resp) begin
            outstanding_nxt = outstanding + CNT_ONE;
        end else if (!issue && resp) begin
            outstanding_nxt = outstanding - CNT_ONE;
        end
    end

    always_comb begin
        fifo_count_nxt = fifo_count;
        if (push && !pop) begin
            fifo_count_nxt = fifo_count + CNT_ONE;
        end else if (pop && !push) begin
            fifo_count_nxt = fifo_count - CNT_ONE;
        end
    end

    // On redirect every fetch still in flight after this cycle's response
    // must be discarded; outstanding_nxt already covers older drops too.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc         <= redirect_aligned;
                resp_pc    <= redirect_aligned;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                drop_cnt   <= outstanding_nxt;
            end else begin
                if (issue) begin
                    pc <= pc + PC_W'(4);
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_W'(4);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                fifo_count <= fifo_count_nxt;
            end
        end
    end

    // Storage needs no reset; fifo_count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    assign head_valid     = (fifo_count != '0);
    assign head_inst      = head_valid ? fifo_inst[rd_ptr] : NOP;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_inst;
    assign bus.inst_pc    = head_valid ? fifo_pc[rd_ptr] : '0;
    assign bus.opcode     = head_inst[6:0];

    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(push && !pop && (fifo_count == CNT_W'(DEPTH)))
    );

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Purpose : self-checking bench for ifetch_unit. A behavioural memory returns
//           a word derived from each granted address after a configurable
//           latency. Each granted request is tagged with a redirect epoch;
//           a response is expected in the decode stream only if its epoch is
//           still current and it does not land in a redirect cycle. Expected
//           words are queued on response and compared when decode pops them.
//           A phase table drives the main stream scenarios; hand-written
//           sequences cover reset latency, flushes and double redirects.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (selects the misaligned
// redirect scenario that matches the design build).
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    ifetch_unit_if #(.PC_W(32)) bus ();

    ifetch_unit #(
        .PC_W     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        int          lat;
        bit          gnt_toggle;
        int          ready_off;
        int          cycles;
        logic [31:0] start_pc;
        logic [31:0] exp_first_pc;
        int          min_pops;
    } vec_t;

    req_t        pending[$];
    exp_t        exp_q[$];
    vec_t        vecs[4];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    bit          gnt_toggle = 1'b0;
    int          ready_off = 0;
    int          pops = 0;
    bit          got_first = 1'b0;
    logic [31:0] first_pop_pc = '0;
    logic [31:0] exp_pc = '0;
    bit          exp_fault = 1'b0;
    int          since_reset = 0;
    int          first_valid_at = -1;

    logic        s_req, s_gnt, s_rvalid, s_redirect, s_reset;
    logic [31:0] s_addr, s_rpc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory answers the oldest pending request once its latency has elapsed.
    task automatic mem_drive();
        if (!reset && (pending.size() != 0) && (pending[0].due <= cyc)) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = word_of(pending[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
    endtask

    task automatic checkOutput();
        bit exp_req;
        exp_req = !reset && !redirect_valid && !exp_fault
                  && ((exp_q.size() + pending.size()) < DEPTH);
        check("imem_req", 32'(bus.imem_req), 32'(exp_req));
        if (bus.imem_req) begin
            check("imem_addr", bus.imem_addr, exp_pc);
        end
        check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("inst_pc", bus.inst_pc, exp_q[0].pc);
            check("inst", bus.inst, exp_q[0].word);
            check("opcode", 32'(bus.opcode), 32'(exp_q[0].word[6:0]));
        end else begin
            check("inst_idle", bus.inst, NOP);
            check("inst_pc_idle", bus.inst_pc, 32'h0);
            check("opcode_idle", 32'(bus.opcode), 32'h13);
        end
        check("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
        if (bus.inst_valid && (first_valid_at < 0) && !reset) begin
            first_valid_at = since_reset + 1;
        end
        if (bus.inst_valid && bus.inst_ready && !reset && !redirect_valid) begin
            if (!got_first) begin
                got_first    = 1'b1;
                first_pop_pc = bus.inst_pc;
            end
            pops++;
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
        s_req      = bus.imem_req;
        s_gnt      = bus.imem_gnt;
        s_addr     = bus.imem_addr;
        s_rvalid   = bus.imem_rvalid;
        s_redirect = redirect_valid;
        s_rpc      = redirect_pc;
        s_reset    = reset;
    endtask

    task automatic advance();
        req_t r;
        @(posedge clk);
        if (s_reset) begin
            pending.delete();
            exp_q.delete();
            exp_pc      = 32'h0;
            exp_fault   = 1'b0;
            epoch++;
            since_reset = 0;
        end else begin
            if (s_rvalid) begin
                r = pending.pop_front();
                if (!s_redirect && (r.epoch == epoch)) begin
                    exp_q.push_back('{pc: r.addr, word: word_of(r.addr)});
                end
            end
            if (s_req && s_gnt) begin
                pending.push_back('{addr: s_addr, epoch: epoch, due: cyc + lat});
                exp_pc = exp_pc + 32'd4;
            end
            if (s_redirect) begin
                exp_q.delete();
                epoch++;
                exp_pc = s_rpc & ~32'h3;
`ifdef IFETCH_ALIGN_CHECK_EN
                if (s_rpc[1:0] != 2'b00) begin
                    exp_fault = 1'b1;
                end
`endif
            end
            since_reset++;
        end
        cyc++;
        #1;
    endtask

    // One clock cycle: drive inputs, let them settle, compare, then clock.
    task automatic applyStimulus(input bit rv, input logic [31:0] rpc);
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.imem_gnt   = gnt_toggle ? cyc[0] : 1'b1;
        if (ready_off > 0) begin
            bus.inst_ready = 1'b0;
            ready_off--;
        end else begin
            bus.inst_ready = 1'b1;
        end
        mem_drive();
        #1;
        checkOutput();
        advance();
    endtask

    initial begin
        // lat, gnt_toggle, ready_off, cycles, start_pc, exp_first_pc, min_pops
        vecs[0] = '{1, 1'b0, 0, 20, 32'h0000_0000, 32'h0000_0000, 5};
        vecs[1] = '{1, 1'b0, 6, 20, 32'h0000_0000, 32'h0000_0000, 4};
        vecs[2] = '{3, 1'b1, 0, 40, 32'h0000_0040, 32'h0000_0040, 4};
        vecs[3] = '{2, 1'b1, 3, 30, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 3};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.imem_gnt   = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, then first fetch latency with a 1-cycle memory.
        repeat (2) applyStimulus(1'b0, 32'h0);
        reset = 1'b0;
        lat = 1;
        first_valid_at = -1;
        got_first = 1'b0;
        repeat (8) applyStimulus(1'b0, 32'h0);
        check("first_valid_cycle", first_valid_at, 32'd3);
        check("first_pc_after_reset", first_pop_pc, 32'h0);

        // Table-driven stream phases, each started by a redirect.
        for (int i = 0; i < 4; i++) begin
            lat        = vecs[i].lat;
            gnt_toggle = vecs[i].gnt_toggle;
            applyStimulus(1'b1, vecs[i].start_pc);
            ready_off = vecs[i].ready_off;
            got_first = 1'b0;
            pops      = 0;
            repeat (vecs[i].cycles) applyStimulus(1'b0, 32'h0);
            check($sformatf("phase%0d_popped", i), 32'(got_first), 32'd1);
            check($sformatf("phase%0d_first_pc", i), first_pop_pc, vecs[i].exp_first_pc);
            checks++;
            if (pops < vecs[i].min_pops) begin
                failures++;
                $display("[TB] FAIL phase%0d_pops: got %0d expected at least %0d", i, pops, vecs[i].min_pops);
            end
        end

        // Two fetches in flight (0x10, 0x14) are flushed by a redirect.
        lat        = 3;
        gnt_toggle = 1'b0;
        applyStimulus(1'b1, 32'h10);
        for (int k = 0; k < 10; k++) begin
            if (pending.size() == 2) break;
            applyStimulus(1'b0, 32'h0);
        end
        check("inflight_count", pending.size(), 32'd2);
        if (pending.size() == 2) begin
            check("inflight_addr0", pending[0].addr, 32'h10);
            check("inflight_addr1", pending[1].addr, 32'h14);
        end
        applyStimulus(1'b1, 32'h100);
        got_first = 1'b0;
        repeat (15) applyStimulus(1'b0, 32'h0);
        check("flush_first_pc", first_pop_pc, 32'h100);

        // Redirect coinciding with rvalid and a pop, then a second redirect.
        begin
            bit found;
            lat   = 1;
            found = 1'b0;
            applyStimulus(1'b1, 32'h40);
            for (int k = 0; k < 20; k++) begin
                if ((pending.size() != 0) && (pending[0].due <= cyc) && bus.inst_valid) begin
                    found = 1'b1;
                    break;
                end
                applyStimulus(1'b0, 32'h0);
            end
            check("collision_setup", 32'(found), 32'd1);
            applyStimulus(1'b1, 32'h300);
            applyStimulus(1'b1, 32'h200);
            got_first = 1'b0;
            repeat (12) applyStimulus(1'b0, 32'h0);
            check("double_redirect_first_pc", first_pop_pc, 32'h200);
        end

        // Misaligned redirect.
`ifdef IFETCH_ALIGN_CHECK_EN
        applyStimulus(1'b1, 32'h102);
        check("fault_set", 32'(fetch_fault), 32'd1);
        repeat (6) applyStimulus(1'b0, 32'h0);
        check("fault_sticky", 32'(fetch_fault), 32'd1);
`else
        applyStimulus(1'b1, 32'h102);
        got_first = 1'b0;
        repeat (15) applyStimulus(1'b0, 32'h0);
        check("misaligned_first_pc", first_pop_pc, 32'h100);
`endif

        // Reset in the middle of a running stream.
        reset = 1'b1;
        repeat (2) applyStimulus(1'b0, 32'h0);
        reset = 1'b0;
        got_first = 1'b0;
        repeat (12) applyStimulus(1'b0, 32'h0);
        check("reset_restart_pc", first_pop_pc, 32'h0);
        check("fault_after_reset", 32'(fetch_fault), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
